// File: rtl/wb_switch_n_pkg.sv
// Shared types and defaults for the Wishbone 1-master/N-slave switch:
// FSM state encoding, default bus widths and the error-counter helper.
package wb_switch_n_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } wb_state_e;

  localparam int WB_AW_DEF      = 32;
  localparam int WB_DW_DEF      = 32;
  localparam int WB_TIMEOUT_DEF = 255;

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_switch_n_addr_decode.sv
// Combinational priority address decoder: lowest matching slave index wins,
// miss is raised when no slave window matches.
module wb_switch_n_addr_decode
  import wb_switch_n_pkg::*;
#(
  parameter int                    NSLAVE     = 4,
  parameter int                    AW         = WB_AW_DEF,
  parameter logic [NSLAVE*AW-1:0]  SLAVE_ADDR = '0,
  parameter logic [NSLAVE*AW-1:0]  SLAVE_MASK = '0
) (
  input  logic [AW-1:0]     adr,
  output logic [NSLAVE-1:0] hit,
  output logic              miss
);

  logic found;

  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (!found && (((adr ^ SLAVE_ADDR[i*AW +: AW]) & SLAVE_MASK[i*AW +: AW]) == '0)) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    miss = !found;
  end

endmodule

// File: rtl/wb_switch_n.sv
// Wishbone classic 1-master/N-slave switch with latched slave select, built-in
// default slave, stall timeout and bus-error logging.
module wb_switch_n
  import wb_switch_n_pkg::*;
#(
  parameter int                    NSLAVE       = 4,
  parameter int                    AW           = WB_AW_DEF,
  parameter int                    DW           = WB_DW_DEF,
  parameter logic [NSLAVE*AW-1:0]  SLAVE_ADDR   = '0,
  parameter logic [NSLAVE*AW-1:0]  SLAVE_MASK   = '0,
  parameter int                    TIMEOUT      = WB_TIMEOUT_DEF,
  parameter logic [DW-1:0]         DEFAULT_DATA = DW'(32'hAAAAAAAA),
  parameter bit                    MISS_ERR     = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        m_adr_i,
  input  logic [DW-1:0]        m_dat_i,
  output logic [DW-1:0]        m_dat_o,
  input  logic [DW/8-1:0]      m_sel_i,
  input  logic                 m_we_i,
  input  logic                 m_cyc_i,
  input  logic                 m_stb_i,
  output logic                 m_ack_o,
  output logic                 m_err_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [DW/8-1:0]      s_sel_o,
  output logic                 s_we_o,
  output logic [NSLAVE-1:0]    s_cyc_o,
  output logic [NSLAVE-1:0]    s_stb_o,
  input  logic [NSLAVE*DW-1:0] s_dat_i,
  input  logic [NSLAVE-1:0]    s_ack_i,
  input  logic                 err_clr,
  output logic [AW-1:0]        err_adr_o,
  output logic [7:0]           err_cnt_o
);

  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  wb_state_e         state_q, state_d;
  logic [NSLAVE-1:0] sel_q, sel_d;
  logic              miss_q, miss_d;
  logic [7:0]        tcnt_q, tcnt_d;
  logic [AW-1:0]     err_adr_q, err_adr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic [NSLAVE-1:0] hit;
  logic              miss;
  logic              active, done, timeout, ack, err;
  logic              slave_ack;
  logic [DW-1:0]     slave_dat;

  wb_switch_n_addr_decode #(
    .NSLAVE     (NSLAVE),
    .AW         (AW),
    .SLAVE_ADDR (SLAVE_ADDR),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .adr  (m_adr_i),
    .hit  (hit),
    .miss (miss)
  );

  // sel_q is one-hot, so OR-reduction acts as the mux and masks unselected acks.
  always_comb begin
    slave_ack = 1'b0;
    slave_dat = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (sel_q[i]) begin
        slave_ack = slave_ack | s_ack_i[i];
        slave_dat = slave_dat | s_dat_i[i*DW +: DW];
      end
    end
  end

  assign active  = (state_q == ST_ACTIVE) && m_cyc_i;
  assign done    = active && (miss_q ? m_stb_i : slave_ack);
  assign timeout = active && !done && (tcnt_q == TLAST);
  assign ack     = done && !(miss_q && MISS_ERR);
  assign err     = (done && miss_q && MISS_ERR) || timeout;

  assign m_ack_o = ack;
  assign m_err_o = err;
  assign m_dat_o = ack ? (miss_q ? DEFAULT_DATA : slave_dat) : '0;

  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;
  assign s_we_o  = m_we_i;
  assign s_cyc_o = active ? sel_q : '0;
  assign s_stb_o = (active && m_stb_i && !timeout) ? sel_q : '0;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    miss_d    = miss_q;
    tcnt_d    = tcnt_q;
    err_adr_d = err_adr_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          state_d = ST_ACTIVE;
          sel_d   = hit;
          miss_d  = miss;
          tcnt_d  = '0;
        end
      end
      ST_ACTIVE: begin
        if (!m_cyc_i || done || timeout) state_d = ST_IDLE;
        else                             tcnt_d  = tcnt_q + 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    // A clear in the same cycle as an error discards that error.
    if (err_clr) begin
      err_adr_d = '0;
      err_cnt_d = '0;
    end else if (err) begin
      err_adr_d = m_adr_i;
      err_cnt_d = sat_inc8(err_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      miss_q    <= 1'b0;
      tcnt_q    <= '0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      miss_q    <= miss_d;
      tcnt_q    <= tcnt_d;
      err_adr_q <= err_adr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_adr_o = err_adr_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_wb_switch_n.sv
// Directed bench for wb_switch_n: two instances (ack-on-miss and err-on-miss maps)
// driven by a linear sequence, responses checked against a scoreboard queue.
module tb_wb_switch_n;

  localparam logic [31:0] ROM_D = 32'hC0DE0001;
  localparam logic [31:0] TUB_D = 32'h7E7E0002;
  localparam logic [31:0] RAM_D = 32'h5A5A0003;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m_adr [2];
  logic [31:0] m_dat_w [2];
  logic [31:0] m_dat_r [2];
  logic [3:0]  m_sel [2];
  logic        m_we [2];
  logic        m_cyc [2];
  logic        m_stb [2];
  logic        m_ack [2];
  logic        m_err [2];
  logic [31:0] s_adr [2];
  logic [31:0] s_dat_w [2];
  logic [3:0]  s_sel [2];
  logic        s_we [2];
  logic [2:0]  s_cyc [2];
  logic [2:0]  s_stb [2];
  logic [2:0]  s_ack [2];
  logic        err_clr [2];
  logic [31:0] err_adr [2];
  logic [7:0]  err_cnt [2];
  logic [95:0] s_dat;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] dat;
    int          cyc;
    logic [2:0]  stb1;
    logic [2:0]  stbr;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // dut0: ROM/Tube/RAM map, miss acks with default data.
  wb_switch_n #(
    .NSLAVE(3), .AW(32), .DW(32),
    .SLAVE_ADDR({32'h00000000, 32'h01000000, 32'h03000000}),
    .SLAVE_MASK({32'h03E00000, 32'h03000000, 32'h03000000}),
    .TIMEOUT(8), .DEFAULT_DATA(32'hAAAAAAAA), .MISS_ERR(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr[0]), .m_dat_i(m_dat_w[0]), .m_dat_o(m_dat_r[0]), .m_sel_i(m_sel[0]),
    .m_we_i(m_we[0]), .m_cyc_i(m_cyc[0]), .m_stb_i(m_stb[0]),
    .m_ack_o(m_ack[0]), .m_err_o(m_err[0]),
    .s_adr_o(s_adr[0]), .s_dat_o(s_dat_w[0]), .s_sel_o(s_sel[0]), .s_we_o(s_we[0]),
    .s_cyc_o(s_cyc[0]), .s_stb_o(s_stb[0]), .s_dat_i(s_dat), .s_ack_i(s_ack[0]),
    .err_clr(err_clr[0]), .err_adr_o(err_adr[0]), .err_cnt_o(err_cnt[0])
  );

  // dut1: ROM at 0 overlapping RAM, miss raises an error.
  wb_switch_n #(
    .NSLAVE(3), .AW(32), .DW(32),
    .SLAVE_ADDR({32'h00000000, 32'h01000000, 32'h00000000}),
    .SLAVE_MASK({32'h03E00000, 32'h03000000, 32'h03FFFFFC}),
    .TIMEOUT(8), .DEFAULT_DATA(32'hAAAAAAAA), .MISS_ERR(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr[1]), .m_dat_i(m_dat_w[1]), .m_dat_o(m_dat_r[1]), .m_sel_i(m_sel[1]),
    .m_we_i(m_we[1]), .m_cyc_i(m_cyc[1]), .m_stb_i(m_stb[1]),
    .m_ack_o(m_ack[1]), .m_err_o(m_err[1]),
    .s_adr_o(s_adr[1]), .s_dat_o(s_dat_w[1]), .s_sel_o(s_sel[1]), .s_we_o(s_we[1]),
    .s_cyc_o(s_cyc[1]), .s_stb_o(s_stb[1]), .s_dat_i(s_dat), .s_ack_i(s_ack[1]),
    .err_clr(err_clr[1]), .err_adr_o(err_adr[1]), .err_cnt_o(err_cnt[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one read on dut d; slave acks (all lines) in ACTIVE cycle ack_at,
  // unselected lines in unsel are pulsed every earlier ACTIVE cycle.
  task automatic run_txn(input int d, input logic [31:0] adr, input int ack_at,
                         input logic [2:0] unsel, input int budget, input string tag);
    exp_t        e;
    int          got_c = 0;
    logic        g_ack = 1'b0;
    logic        g_err = 1'b0;
    logic [31:0] g_dat = '0;
    logic [2:0]  stb_first = '0;
    logic [2:0]  stb_resp = '0;
    @(negedge clk);
    m_adr[d] = adr; m_we[d] = 1'b0; m_cyc[d] = 1'b1; m_stb[d] = 1'b1;
    #1 chk({tag, "_idle_stb"}, 32'(s_stb[d]), 32'd0);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      s_ack[d] = (c == ack_at) ? 3'b111 : unsel;
      #1;
      if (c == 1) stb_first = s_stb[d];
      if (m_ack[d] || m_err[d]) begin
        got_c = c; g_ack = m_ack[d]; g_err = m_err[d]; g_dat = m_dat_r[d]; stb_resp = s_stb[d];
        break;
      end
    end
    @(negedge clk);
    m_cyc[d] = 1'b0; m_stb[d] = 1'b0; s_ack[d] = 3'b000;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_cycle"}, 32'(got_c), 32'(e.cyc));
      chk({tag, "_ack"}, 32'(g_ack), 32'(e.ack));
      chk({tag, "_err"}, 32'(g_err), 32'(e.err));
      chk({tag, "_dat"}, g_dat, e.dat);
      chk({tag, "_stb_first"}, 32'(stb_first), 32'(e.stb1));
      chk({tag, "_stb_resp"}, 32'(stb_resp), 32'(e.stbr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   npulse;
    logic seen;
    rst   = 1'b1;
    s_dat = {RAM_D, TUB_D, ROM_D};
    for (int d = 0; d < 2; d++) begin
      m_adr[d] = '0; m_dat_w[d] = '0; m_sel[d] = '0; m_we[d] = 1'b0;
      m_cyc[d] = 1'b0; m_stb[d] = 1'b0; s_ack[d] = '0; err_clr[d] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", 32'(m_ack[d]), 32'd0);
      chk("rst_err", 32'(m_err[d]), 32'd0);
      chk("rst_cyc", 32'(s_cyc[d]), 32'd0);
      chk("rst_stb", 32'(s_stb[d]), 32'd0);
      chk("rst_dat", m_dat_r[d], 32'd0);
      chk("rst_err_adr", err_adr[d], 32'd0);
      chk("rst_err_cnt", 32'(err_cnt[d]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Broadcast path with no cycle in progress
    for (int d = 0; d < 2; d++) begin
      m_adr[d] = 32'h12345678 + 32'(d); m_dat_w[d] = 32'hCAFEF00D ^ 32'(d);
      m_sel[d] = 4'hA; m_we[d] = 1'b1;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("bcast_adr", s_adr[d], 32'h12345678 + 32'(d));
      chk("bcast_dat", s_dat_w[d], 32'hCAFEF00D ^ 32'(d));
      chk("bcast_sel", 32'(s_sel[d]), 32'hA);
      chk("bcast_we", 32'(s_we[d]), 32'd1);
      chk("bcast_no_cyc", 32'(s_cyc[d]), 32'd0);
    end

    // ROM read, unselected Tube/RAM acks ignored
    sb.push_back('{ack: 1'b1, err: 1'b0, dat: ROM_D, cyc: 1, stb1: 3'b001, stbr: 3'b001});
    run_txn(0, 32'h03001858, 1, 3'b110, 20, "rom_read");

    // Overlap: ROM at 0 shadows RAM
    sb.push_back('{ack: 1'b1, err: 1'b0, dat: ROM_D, cyc: 2, stb1: 3'b001, stbr: 3'b001});
    run_txn(1, 32'h00000000, 2, 3'b110, 20, "overlap");

    // Miss: default data on dut0, error on dut1
    sb.push_back('{ack: 1'b1, err: 1'b0, dat: 32'hAAAAAAAA, cyc: 1, stb1: 3'b000, stbr: 3'b000});
    run_txn(0, 32'h02000000, 0, 3'b111, 20, "miss_ack");
    sb.push_back('{ack: 1'b0, err: 1'b1, dat: 32'h0, cyc: 1, stb1: 3'b000, stbr: 3'b000});
    run_txn(1, 32'h02000000, 0, 3'b111, 20, "miss_err");
    #1;
    chk("miss_err_adr", err_adr[1], 32'h02000000);
    chk("miss_err_cnt", 32'(err_cnt[1]), 32'd1);
    chk("miss_ack_no_log", 32'(err_cnt[0]), 32'd0);

    // Timeout on RAM, then ack exactly on the timeout cycle
    sb.push_back('{ack: 1'b0, err: 1'b1, dat: 32'h0, cyc: 8, stb1: 3'b100, stbr: 3'b000});
    run_txn(0, 32'h00000040, 0, 3'b011, 20, "timeout");
    #1;
    chk("timeout_err_cnt", 32'(err_cnt[0]), 32'd1);
    chk("timeout_err_adr", err_adr[0], 32'h00000040);
    chk("timeout_idle_stb", 32'(s_stb[0]), 32'd0);
    sb.push_back('{ack: 1'b1, err: 1'b0, dat: RAM_D, cyc: 8, stb1: 3'b100, stbr: 3'b100});
    run_txn(0, 32'h00000040, 8, 3'b011, 20, "ack_at_timeout");
    #1 chk("ack_at_timeout_no_log", 32'(err_cnt[0]), 32'd1);

    // Master drops cyc mid-wait
    @(negedge clk);
    m_adr[0] = 32'h00000040; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    repeat (3) @(negedge clk);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1;
    chk("abort_ack", 32'(m_ack[0]), 32'd0);
    chk("abort_err", 32'(m_err[0]), 32'd0);
    chk("abort_cyc", 32'(s_cyc[0]), 32'd0);
    @(negedge clk);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    #1 chk("abort_back_idle_stb", 32'(s_stb[0]), 32'd0);
    @(negedge clk);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    repeat (10) @(negedge clk);
    #1 chk("abort_no_log", 32'(err_cnt[0]), 32'd1);

    // Reset mid-cycle
    @(negedge clk);
    m_adr[0] = 32'h00000040; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(negedge clk);
    #1 chk("midrst_active_stb", 32'(s_stb[0]), 32'b100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; s_ack[0] = 3'b111;
    #1;
    chk("midrst_ack", 32'(m_ack[0]), 32'd0);
    chk("midrst_err", 32'(m_err[0]), 32'd0);
    chk("midrst_stb", 32'(s_stb[0]), 32'd0);
    chk("midrst_cyc", 32'(s_cyc[0]), 32'd0);
    chk("midrst_dat", m_dat_r[0], 32'd0);
    chk("midrst_err_cnt", 32'(err_cnt[0]), 32'd0);
    chk("midrst_err_adr", err_adr[0], 32'd0);
    @(negedge clk);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack[0] = 3'b000;

    // 300 back-to-back miss errors saturate the counter
    @(negedge clk);
    m_adr[1] = 32'h02000000; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    npulse = 0;
    for (int i = 0; i < 1000 && npulse < 300; i++) begin
      @(negedge clk);
      #1;
      if (m_err[1]) npulse++;
    end
    chk("sat_pulses", 32'(npulse), 32'd300);
    @(negedge clk);
    #1;
    chk("sat_err_cnt", 32'(err_cnt[1]), 32'hFF);
    chk("sat_err_adr", err_adr[1], 32'h02000000);

    // Clear with a concurrent error: log clears, error dropped
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (m_err[1]) begin
        err_clr[1] = 1'b1;
        seen = 1'b1;
        break;
      end
    end
    chk("clr_err_seen", 32'(seen), 32'd1);
    @(negedge clk);
    err_clr[1] = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    #1;
    chk("clr_err_cnt", 32'(err_cnt[1]), 32'd0);
    chk("clr_err_adr", err_adr[1], 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
